// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the ARM7TDMI instruction fetch stage.
package arm_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [31:0] ARM_STEP     = 32'd4;
  localparam logic [31:0] THUMB_STEP   = 32'd2;
  localparam logic [31:0] ARM_PC_OFS   = 32'd8;
  localparam logic [31:0] THUMB_PC_OFS = 32'd4;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] HALF_MASK    = 32'hFFFF_FFFE;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instr} entries with flush and
// same-cycle push+pop (allowed even when full).
module fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [PC_W-1:0]        push_pc_i,
  input  logic [INSTR_W-1:0]     push_instr_i,
  input  logic                   pop_i,
  output logic [PC_W-1:0]        head_pc_o,
  output logic [INSTR_W-1:0]     head_instr_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok_s, pop_ok_s;

  assign empty_o      = (cnt_q == {CW{1'b0}});
  assign full_o       = (cnt_q == FULL_C);
  assign count_o      = cnt_q;
  assign pop_ok_s     = pop_i && !empty_o;
  // A pop frees the head slot in the same edge, so a full queue may still accept.
  assign push_ok_s    = push_i && (!full_o || pop_ok_s);
  assign head_pc_o    = mem_q[rd_q].pc;
  assign head_instr_o = mem_q[rd_q].instr;

  // Pointer and occupancy next state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = {AW{1'b0}};
      rd_d  = {AW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_d = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok_s) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      cnt_d = cnt_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= {AW{1'b0}};
      rd_q  <= {AW{1'b0}};
      cnt_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok_s && !flush_i) begin
        mem_q[wr_q] <= '{pc: push_pc_i, instr: push_instr_i};
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// ARM7TDMI fetch stage: fetch PC, one-outstanding imem requests, prefetch
// queue and branch redirect. Thumb support is built when FETCH_THUMB_EN is defined.
module fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus8,
  input  logic        branch_taken,
  input  logic [31:0] new_PC
`ifdef FETCH_THUMB_EN
  ,
  input  logic        thumb
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic [31:0]   target_s, step_s, head_pc_s, head_instr_s;
  logic [CW-1:0] count_s, count_after_s;
  logic          full_s, empty_s, push_s, pop_s;

  assign instr_valid   = !empty_s;
  assign pop_s         = instr_valid && instr_ready;
  assign imem_req      = (state_q != IDLE);
  // While discarding, the abandoned request keeps its original address.
  assign imem_addr     = (state_q == DISCARD) ? hold_addr_q : (fetch_pc_q & WORD_MASK);
  assign count_after_s = count_s + CW'(1) - CW'(pop_s);
  assign instr_pc      = head_pc_s;

`ifdef FETCH_THUMB_EN
  logic thumb_q;

  // Instruction-set state changes only on a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      thumb_q <= 1'b0;
    end else if (branch_taken) begin
      thumb_q <= thumb;
    end else begin
      thumb_q <= thumb_q;
    end
  end

  assign step_s         = thumb_q ? THUMB_STEP : ARM_STEP;
  assign target_s       = new_PC & (thumb ? HALF_MASK : WORD_MASK);
  assign instr          = !thumb_q ? head_instr_s :
                          (head_pc_s[1] ? {16'h0000, head_instr_s[31:16]}
                                        : {16'h0000, head_instr_s[15:0]});
  assign instr_pc_plus8 = head_pc_s + (thumb_q ? THUMB_PC_OFS : ARM_PC_OFS);
`else
  assign step_s         = ARM_STEP;
  assign target_s       = new_PC & WORD_MASK;
  assign instr          = head_instr_s;
  assign instr_pc_plus8 = head_pc_s + ARM_PC_OFS;
`endif

  // Fetch FSM next state, fetch pointer and queue push
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    push_s      = 1'b0;
    if (branch_taken) begin
      fetch_pc_d = target_s;
      if ((state_q != IDLE) && !imem_ack) begin
        state_d     = DISCARD;
        hold_addr_d = imem_addr;
      end else begin
        state_d = REQ;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!full_s) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
        REQ: begin
          if (imem_ack) begin
            push_s     = 1'b1;
            fetch_pc_d = fetch_pc_q + step_s;
            state_d    = (count_after_s < DEPTH_C) ? REQ : IDLE;
          end else begin
            state_d = REQ;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            state_d = REQ;
          end else begin
            state_d = DISCARD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Fetch FSM state and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_VECTOR;
      hold_addr_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (branch_taken),
    .push_i      (push_s),
    .push_pc_i   (fetch_pc_q),
    .push_instr_i(imem_rdata),
    .pop_i       (pop_s),
    .head_pc_o   (head_pc_s),
    .head_instr_o(head_instr_s),
    .count_o     (count_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the ARM7TDMI core: owns the fetch PC, issues word requests to instruction memory, and buffers returned words in a small prefetch queue for decode. It consumes the branch redirect (branch_taken, new_PC) from the branch Control stage, flushes all prefetched and in-flight instructions, and restarts fetch at the target. It also provides the architectural PC+8 value that execute reads as r15.

Parameters:
RESET_VECTOR, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, prefetch queue entries (power of two, >=2)

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
imem_req  output  1  memory request valid
imem_addr  output  32  word-aligned request address
imem_ack  input  1  request accepted and data returned this cycle
imem_rdata  input  32  instruction word, valid with imem_ack
instr_valid  output  1  queue head valid to decode
instr_ready  input  1  decode accepts head
instr  output  32  head instruction word
instr_pc  output  32  address of head instruction
instr_pc_plus8  output  32  instr_pc + 8 (r15 read value)
branch_taken  input  1  redirect pulse from Control
new_PC  input  32  redirect target, valid with branch_taken

Behaviour:
- Reset (sync, rst=1 at posedge): fetch_pc=RESET_VECTOR, queue empty, state=IDLE, imem_req=0, instr_valid=0, instr/instr_pc=0, instr_pc_plus8=8. Reset mid-transaction drops any outstanding request; an ack seen in DISCARD-equivalent cycles after reset is ignored.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE: if (queue count + outstanding) < FIFO_DEPTH -> REQ next cycle.
  - REQ: imem_req=1, imem_addr=fetch_pc held stable until imem_ack. On ack: push {fetch_pc, imem_rdata}, fetch_pc += 4 (wraps modulo 2^32, 32'hFFFF_FFFC -> 0); stay in REQ if space remains after push, else IDLE.
  - DISCARD: entered when branch_taken arrives while a request is outstanding without ack that cycle; imem_req held with old address until imem_ack; ack data dropped; then REQ at the redirect target.
- At most one outstanding request; 1-cycle minimum from ack to the next request address (back-to-back REQ allowed).
- Latency: with memory acking in the same cycle, instruction at address A is visible on instr one cycle after the ack that returns it.
- Decode handshake: pop when instr_valid && instr_ready. instr/instr_pc held stable while instr_valid && !instr_ready.
- Simultaneous push and pop on a full queue is allowed; the count is unchanged.
- Branch redirect (branch_taken=1): at the next edge the queue is cleared, instr_valid=0, and fetch_pc={new_PC[31:2],2'b00}. A pop in the same cycle completes; a push in the same cycle is discarded. If an ack coincides with branch_taken, that data is dropped and the state goes straight to REQ at the target, not DISCARD. Back-to-back branch pulses: the last one wins.
- First instruction from the target is presented no earlier than 2 cycles after branch_taken.

Optional Feature:
FETCH_THUMB_EN
- Defined: adds input thumb (1). When thumb=1:
  - the fetch pointer advances by 2;
  - the redirect target is masked to {new_PC[31:1],1'b0};
  - imem_addr remains word-aligned (fetch_pc[31:2]);
  - instr = zero-extended halfword selected by instr_pc[1];
  - instr_pc_plus8 becomes instr_pc + 4.
  A change of thumb takes effect only via a branch redirect.
- Undefined: ARM state only, no thumb port, and the behaviour is exactly as above.

Decomposition:
- Package arm_fetch_pkg: FSM state enum (IDLE/REQ/DISCARD), RESET_VECTOR default, instruction width and PC step constants, and the queue entry struct {pc, instr}.
- One sub-module: fetch_fifo. It is a synchronous FIFO with a flush input, push/pop, count, full/empty, and same-cycle push+pop support.

Test Plan:
1. Reset then release, memory acks every cycle -> imem_addr 0x0, 0x4, 0x8; instr_pc=0x0 first; instr_pc_plus8=0x8.
2. instr_ready=0 for 5 cycles -> at most 2 entries queued, imem_req drops, head stays 0x0; release -> 0x0, 0x4, 0x8 in order with no loss.
3. branch_taken with new_PC=0x100 while the queue holds 0x8/0xC -> next cycle instr_valid=0; next imem_addr=0x100; first instr_pc=0x100.
4. branch_taken with new_PC=0x203 while a request to 0x10 is pending and ack arrives 3 cycles later -> 0x10 data dropped (DISCARD), then imem_addr=0x200.
5. fetch_pc=0xFFFF_FFFC -> next address 0x0000_0000, no X.
6. FETCH_THUMB_EN, branch to 0x102 with thumb=1 -> instr_pc 0x102, 0x104; imem_addr 0x100, 0x104; upper halfword of word 0x100 is selected first.
